// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small TX FIFO and a configurable frame:
// 5..9 data bits, LSB/MSB first, none/even/odd parity, 1 or 2 stop bits.
module uart_tx_fifo #(
   parameter int    DATA_BITS  = 8,
   parameter string FIRST_BIT  = "lsb",
   parameter string PARITY     = "none",
   parameter int    STOP_BITS  = 1,
   parameter int    CLK_FREQ   = 18_750_000,
   parameter int    BAUDRATE   = 115200,
   parameter int    FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   input  logic [DATA_BITS-1:0]          tx_data,
   output logic                          tx,
   output logic                          busy,
   output logic                          bit_strobe,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int DIV       = CLK_FREQ / BAUDRATE;
   localparam int CW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW        = $clog2(FIFO_DEPTH);
   localparam int LW        = AW + 1;
   localparam bit MSB_FIRST = (FIRST_BIT == "msb");
   localparam bit ODD_PAR   = (PARITY == "odd");
   localparam bit HAS_PAR   = (PARITY == "even") || (PARITY == "odd");

   typedef enum logic [2:0] {
      S_RESET, S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;

   state_t               state, state_nxt;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic [3:0]           idx, idx_nxt;
   logic [DATA_BITS-1:0] shreg, shreg_nxt;
   logic                 par_bit, par_nxt;
   logic                 tx_nxt, busy_nxt, strobe_nxt;
   logic                 bit_end, load_frame, send_data;

   // ---------------- FIFO ----------------
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [DATA_BITS-1:0] head;
   logic                 push, pop, full, empty;

   assign full     = (fifo_level == LW'(FIFO_DEPTH));
   assign empty    = (fifo_level == '0);
   assign tx_ready = (state != S_RESET) && !full;
   assign push     = tx_valid && tx_ready;
   assign head     = mem[rd_ptr];

   // Storage needs no reset: contents are only visible through the pointers.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= tx_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // ---------------- frame sequencer ----------------
   assign bit_end = (cnt == CW'(DIV - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_RESET;
         cnt        <= '0;
         idx        <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         bit_strobe <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         idx        <= idx_nxt;
         shreg      <= shreg_nxt;
         par_bit    <= par_nxt;
         tx         <= tx_nxt;
         busy       <= busy_nxt;
         bit_strobe <= strobe_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      shreg_nxt  = shreg;
      par_nxt    = par_bit;
      tx_nxt     = tx;
      busy_nxt   = busy;
      strobe_nxt = 1'b0;
      load_frame = 1'b0;
      send_data  = 1'b0;
      pop        = 1'b0;

      // Baud counter restarts at every bit boundary and rests at zero when idle.
      if (state == S_RESET || state == S_IDLE || bit_end) cnt_nxt = '0;
      else                                                 cnt_nxt = cnt + 1'b1;

      case (state)
         S_RESET: state_nxt = S_IDLE;
         S_IDLE:  if (!empty) load_frame = 1'b1;
         S_START: begin
            if (bit_end) begin
               state_nxt = S_DATA;
               idx_nxt   = '0;
               send_data = 1'b1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (idx == 4'(DATA_BITS - 1)) begin
                  idx_nxt    = '0;
                  strobe_nxt = 1'b1;
                  if (HAS_PAR) begin
                     state_nxt = S_PARITY;
                     tx_nxt    = par_bit;
                  end else begin
                     state_nxt = S_STOP;
                     tx_nxt    = 1'b1;
                  end
               end else begin
                  idx_nxt   = idx + 1'b1;
                  send_data = 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_nxt  = S_STOP;
               idx_nxt    = '0;
               tx_nxt     = 1'b1;
               strobe_nxt = 1'b1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (idx == 4'(STOP_BITS - 1)) begin
                  if (!empty) begin
                     load_frame = 1'b1;
                  end else begin
                     state_nxt = S_IDLE;
                     tx_nxt    = 1'b1;
                     busy_nxt  = 1'b0;
                  end
               end else begin
                  idx_nxt    = idx + 1'b1;
                  tx_nxt     = 1'b1;
                  strobe_nxt = 1'b1;
               end
            end
         end
         default: state_nxt = S_RESET;
      endcase

      // Pop straight into the start bit so queued frames abut with no idle gap.
      if (load_frame) begin
         pop        = 1'b1;
         state_nxt  = S_START;
         shreg_nxt  = head;
         par_nxt    = ODD_PAR ? ~^head : ^head;
         tx_nxt     = 1'b0;
         strobe_nxt = 1'b1;
         busy_nxt   = 1'b1;
      end

      if (send_data) begin
         strobe_nxt = 1'b1;
         if (MSB_FIRST) begin
            tx_nxt    = shreg[DATA_BITS-1];
            shreg_nxt = shreg << 1;
         end else begin
            tx_nxt    = shreg[0];
            shreg_nxt = shreg >> 1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: three frame configurations at DIV=10,
// FIFO fill/back-to-back, push+pop ordering and reset mid-frame.
module tb_uart_tx_fifo;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // A: 8N1 lsb, B: 8 bits msb even parity 2 stop, C: 7 bits lsb odd parity
   logic       va, ra, txa, busya, stba;
   logic [7:0] da;
   logic [2:0] lvla;
   logic       vb, rb, txb, busyb, stbb;
   logic [7:0] db;
   logic [2:0] lvlb;
   logic       vc, rc, txc, busyc, stbc;
   logic [6:0] dc;
   logic [2:0] lvlc;

   uart_tx_fifo #(.DATA_BITS(8), .FIRST_BIT("lsb"), .PARITY("none"), .STOP_BITS(1),
                  .CLK_FREQ(1_000_000), .BAUDRATE(100_000), .FIFO_DEPTH(4)) dut_a (
      .clk(clk), .reset(reset), .tx_valid(va), .tx_ready(ra), .tx_data(da),
      .tx(txa), .busy(busya), .bit_strobe(stba), .fifo_level(lvla));

   uart_tx_fifo #(.DATA_BITS(8), .FIRST_BIT("msb"), .PARITY("even"), .STOP_BITS(2),
                  .CLK_FREQ(1_000_000), .BAUDRATE(100_000), .FIFO_DEPTH(4)) dut_b (
      .clk(clk), .reset(reset), .tx_valid(vb), .tx_ready(rb), .tx_data(db),
      .tx(txb), .busy(busyb), .bit_strobe(stbb), .fifo_level(lvlb));

   uart_tx_fifo #(.DATA_BITS(7), .FIRST_BIT("lsb"), .PARITY("odd"), .STOP_BITS(1),
                  .CLK_FREQ(1_000_000), .BAUDRATE(100_000), .FIFO_DEPTH(4)) dut_c (
      .clk(clk), .reset(reset), .tx_valid(vc), .tx_ready(rc), .tx_data(dc),
      .tx(txc), .busy(busyc), .bit_strobe(stbc), .fifo_level(lvlc));

   // Line image of an 8N1 frame, bit 0 = start bit.
   function automatic logic [9:0] frame_a(input logic [7:0] d);
      return {1'b1, d, 1'b0};
   endfunction

   task automatic test_reset();
      va = 0; vb = 0; vc = 0; da = '0; db = '0; dc = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if (txa !== 1'b1 || ra !== 1'b0 || busya !== 1'b0 || stba !== 1'b0 || lvla !== 3'd0) begin
         fails++;
         $display("FAIL reset_a: tx=%b ready=%b busy=%b strobe=%b level=%0d, want 1 0 0 0 0",
                  txa, ra, busya, stba, lvla);
      end
      tests++;
      if (txb !== 1'b1 || rb !== 1'b0 || txc !== 1'b1 || rc !== 1'b0) begin
         fails++;
         $display("FAIL reset_bc: txb=%b rb=%b txc=%b rc=%b, want 1 0 1 0", txb, rb, txc, rc);
      end
      reset = 1'b0;
      #1;
      tests++;
      if (ra !== 1'b0) begin
         fails++;
         $display("FAIL ready_in_reset_state: ready=%b, want 0", ra);
      end
      @(negedge clk);
      tests++;
      if (ra !== 1'b1 || rb !== 1'b1 || rc !== 1'b1) begin
         fails++;
         $display("FAIL ready_after_idle: a=%b b=%b c=%b, want 1 1 1", ra, rb, rc);
      end
   endtask

   task automatic test_8n1_lsb();
      logic [9:0] exp;
      int strobes;
      exp = 10'b1101001010;   // 0,1,0,1,0,0,1,0,1,1 on the line
      strobes = 0;
      @(negedge clk);
      va = 1'b1; da = 8'hA5;
      tests++;
      if (ra !== 1'b1) begin
         fails++;
         $display("FAIL 8n1_ready: ready=%b, want 1", ra);
      end
      @(negedge clk);
      va = 1'b0; da = 8'h00;   // changing tx_data after the push must not matter
      tests++;
      if (lvla !== 3'd1 || txa !== 1'b1 || busya !== 1'b0) begin
         fails++;
         $display("FAIL 8n1_queued: level=%0d tx=%b busy=%b, want 1 1 0", lvla, txa, busya);
      end
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (stba) strobes++;
         tests++;
         if (txa !== exp[c/10] || busya !== 1'b1 || stba !== (c % 10 == 0)) begin
            fails++;
            $display("FAIL 8n1_line c=%0d: tx=%b busy=%b strobe=%b, want %b 1 %b",
                     c, txa, busya, stba, exp[c/10], (c % 10 == 0));
         end
      end
      @(negedge clk);
      tests++;
      if (busya !== 1'b0 || txa !== 1'b1 || stba !== 1'b0) begin
         fails++;
         $display("FAIL 8n1_end: busy=%b tx=%b strobe=%b, want 0 1 0", busya, txa, stba);
      end
      tests++;
      if (strobes != 10) begin
         fails++;
         $display("FAIL 8n1_strobes: got %0d, want 10", strobes);
      end
   endtask

   task automatic test_msb_even_2stop();
      logic [11:0] exp;
      int strobes;
      exp = 12'b110110000000; // start, 0000_0011 msb first, parity 0, two stops
      strobes = 0;
      @(negedge clk);
      vb = 1'b1; db = 8'h03;
      @(negedge clk);
      vb = 1'b0; db = 8'hFF;
      for (int c = 0; c < 120; c++) begin
         @(negedge clk);
         if (stbb) strobes++;
         tests++;
         if (txb !== exp[c/10] || busyb !== 1'b1) begin
            fails++;
            $display("FAIL msb_even_line c=%0d: tx=%b busy=%b, want %b 1", c, txb, busyb, exp[c/10]);
         end
      end
      @(negedge clk);
      tests++;
      if (busyb !== 1'b0 || txb !== 1'b1 || strobes != 12) begin
         fails++;
         $display("FAIL msb_even_end: busy=%b tx=%b strobes=%0d, want 0 1 12", busyb, txb, strobes);
      end
   endtask

   task automatic test_7bit_odd();
      logic [9:0] exp;
      int strobes;
      exp = 10'b1100000000;   // start, 7 zeros, odd parity 1, stop
      strobes = 0;
      @(negedge clk);
      vc = 1'b1; dc = 7'h00;
      @(negedge clk);
      vc = 1'b0; dc = 7'h7F;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (stbc) strobes++;
         tests++;
         if (txc !== exp[c/10] || busyc !== 1'b1) begin
            fails++;
            $display("FAIL odd7_line c=%0d: tx=%b busy=%b, want %b 1", c, txc, busyc, exp[c/10]);
         end
      end
      @(negedge clk);
      tests++;
      if (busyc !== 1'b0 || txc !== 1'b1 || strobes != 10) begin
         fails++;
         $display("FAIL odd7_end: busy=%b tx=%b strobes=%0d, want 0 1 10", busyc, txc, strobes);
      end
   endtask

   task automatic test_fifo_full();
      logic [7:0] w [6];
      logic [9:0] f;
      int  idx, cyc, strobes;
      bit  full_seen, started;
      w = '{8'h11, 8'h22, 8'h81, 8'hFF, 8'h00, 8'h3C};
      idx = 0; cyc = 0; strobes = 0; full_seen = 0; started = 0;
      fork
         begin
            while (idx < 6 && cyc < 400) begin
               @(negedge clk);
               cyc++;
               va = 1'b1; da = w[idx];
               if (ra) idx++;
               else if (!full_seen) begin
                  full_seen = 1;
                  tests++;
                  if (idx != 5 || lvla !== 3'd4) begin
                     fails++;
                     $display("FAIL fifo_full_point: accepted=%0d level=%0d, want 5 4", idx, lvla);
                  end
               end
            end
            @(negedge clk);
            va = 1'b0;
            tests++;
            if (idx != 6 || !full_seen) begin
               fails++;
               $display("FAIL fifo_all_accepted: accepted=%0d full_seen=%0d, want 6 1", idx, full_seen);
            end
         end
         begin
            for (int t = 0; t < 50 && !started; t++) begin
               @(negedge clk);
               if (txa === 1'b0) started = 1;
            end
            tests++;
            if (!started) begin
               fails++;
               $display("FAIL fifo_start_timeout: tx stayed %b, want start bit", txa);
            end
            if (started) begin
               for (int c = 0; c < 600; c++) begin
                  if (c > 0) @(negedge clk);
                  if (stba) strobes++;
                  f = frame_a(w[c/100]);
                  tests++;
                  if (txa !== f[(c % 100) / 10] || busya !== 1'b1) begin
                     fails++;
                     $display("FAIL fifo_stream c=%0d: tx=%b busy=%b, want %b 1",
                              c, txa, busya, f[(c % 100) / 10]);
                  end
               end
               @(negedge clk);
               tests++;
               if (busya !== 1'b0 || txa !== 1'b1 || lvla !== 3'd0 || strobes != 60) begin
                  fails++;
                  $display("FAIL fifo_end: busy=%b tx=%b level=%0d strobes=%0d, want 0 1 0 60",
                           busya, txa, lvla, strobes);
               end
            end
         end
      join
   endtask

   task automatic test_push_pop();
      logic [7:0] w [4];
      logic [7:0] sb [$];
      logic [9:0] f;
      bit started;
      w = '{8'h96, 8'h0F, 8'hE1, 8'h7B};
      started = 0;
      fork
         begin
            @(negedge clk); va = 1'b1; da = w[0]; if (ra) sb.push_back(w[0]);
            @(negedge clk); da = w[1]; if (ra) sb.push_back(w[1]);
            @(negedge clk); da = w[2]; if (ra) sb.push_back(w[2]);
            @(negedge clk); va = 1'b0;
            repeat (98) @(negedge clk);   // last clock of the first frame's stop bit
            tests++;
            if (lvla !== 3'd2 || ra !== 1'b1) begin
               fails++;
               $display("FAIL pushpop_pre: level=%0d ready=%b, want 2 1", lvla, ra);
            end
            va = 1'b1; da = w[3]; if (ra) sb.push_back(w[3]);
            @(negedge clk); va = 1'b0;
            tests++;
            if (lvla !== 3'd2) begin
               fails++;
               $display("FAIL pushpop_level: level=%0d, want 2", lvla);
            end
         end
         begin
            for (int t = 0; t < 50 && !started; t++) begin
               @(negedge clk);
               if (txa === 1'b0) started = 1;
            end
            tests++;
            if (!started) begin
               fails++;
               $display("FAIL pushpop_start_timeout: tx stayed %b, want start bit", txa);
            end
            if (started) begin
               for (int c = 0; c < 400; c++) begin
                  if (c > 0) @(negedge clk);
                  if (c % 10 == 5) begin
                     tests++;
                     if (c / 100 >= sb.size()) begin
                        fails++;
                        $display("FAIL pushpop_scoreboard c=%0d: queued=%0d, want > %0d",
                                 c, sb.size(), c / 100);
                     end else begin
                        f = frame_a(sb[c/100]);
                        if (txa !== f[(c % 100) / 10]) begin
                           fails++;
                           $display("FAIL pushpop_order c=%0d: tx=%b, want %b",
                                    c, txa, f[(c % 100) / 10]);
                        end
                     end
                  end
               end
               @(negedge clk);
               tests++;
               if (busya !== 1'b0 || txa !== 1'b1 || sb.size() != 4) begin
                  fails++;
                  $display("FAIL pushpop_end: busy=%b tx=%b queued=%0d, want 0 1 4",
                           busya, txa, sb.size());
               end
            end
         end
      join
   endtask

   task automatic test_reset_mid_frame();
      logic [9:0] exp;
      exp = 10'b1010110100;   // 0x5A: 0,0,1,0,1,1,0,1,0,1 on the line
      @(negedge clk); va = 1'b1; da = 8'hC3;
      @(negedge clk); da = 8'h11;
      @(negedge clk); da = 8'h22;
      @(negedge clk); va = 1'b0;
      repeat (42) @(negedge clk);   // middle of data bit 3 of 0xC3
      tests++;
      if (lvla !== 3'd2 || txa !== 1'b0 || busya !== 1'b1) begin
         fails++;
         $display("FAIL midframe_pre: level=%0d tx=%b busy=%b, want 2 0 1", lvla, txa, busya);
      end
      reset = 1'b1;
      #1;
      tests++;
      if (txa !== 1'b1 || lvla !== 3'd0 || busya !== 1'b0 || ra !== 1'b0) begin
         fails++;
         $display("FAIL midframe_abort: tx=%b level=%0d busy=%b ready=%b, want 1 0 0 0",
                  txa, lvla, busya, ra);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      tests++;
      if (ra !== 1'b0) begin
         fails++;
         $display("FAIL midframe_release_ready: ready=%b, want 0", ra);
      end
      @(negedge clk);
      tests++;
      if (ra !== 1'b1 || txa !== 1'b1 || lvla !== 3'd0) begin
         fails++;
         $display("FAIL midframe_idle: ready=%b tx=%b level=%0d, want 1 1 0", ra, txa, lvla);
      end
      va = 1'b1; da = 8'h5A;
      @(negedge clk);
      va = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         tests++;
         if (txa !== exp[c/10] || busya !== 1'b1) begin
            fails++;
            $display("FAIL midframe_new_frame c=%0d: tx=%b busy=%b, want %b 1",
                     c, txa, busya, exp[c/10]);
         end
      end
      repeat (5) @(negedge clk);
      tests++;
      if (busya !== 1'b0 || txa !== 1'b1 || lvla !== 3'd0) begin
         fails++;
         $display("FAIL midframe_end: busy=%b tx=%b level=%0d, want 0 1 0", busya, txa, lvla);
      end
   endtask

   initial begin
      va = 0; vb = 0; vc = 0; da = '0; db = '0; dc = '0;
      test_reset();
      test_8n1_lsb();
      test_msb_even_2stop();
      test_7bit_odd();
      test_fifo_full();
      test_push_pop();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
